// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave memory port arbiter.
// One outstanding transaction, fixed-priority or round-robin selection, per-transaction watchdog.
module mem_bus_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] ifu_grant_cnt,
    output logic [31:0] lsu_grant_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t      state;
    logic        owner_lsu;
    logic        last_lsu;
    logic [15:0] to_cnt;
    logic        sel_lsu;
    logic        can_accept;
    logic        timed_out;

    // Round-robin hands the tie to whoever did not win last time.
    always_comb begin
        sel_lsu = 1'b0;
        if (lsu_req_valid && !ifu_req_valid) begin
            sel_lsu = 1'b1;
        end else if (lsu_req_valid && ifu_req_valid) begin
            sel_lsu = (PRIO_MODE == 1) ? 1'b1 : !last_lsu;
        end
    end

    assign can_accept    = (state == IDLE) && !rst;
    assign ifu_req_ready = can_accept && ifu_req_valid && !sel_lsu;
    assign lsu_req_ready = can_accept && lsu_req_valid && sel_lsu;
    assign timed_out     = (to_cnt == TO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner_lsu      <= 1'b0;
            last_lsu       <= 1'b1;
            to_cnt         <= '0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
            bus_err        <= 1'b0;
            ifu_grant_cnt  <= '0;
            lsu_grant_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_req_ready || lsu_req_ready) begin
                        state         <= ISSUE;
                        to_cnt        <= '0;
                        mem_req_valid <= 1'b1;
                        owner_lsu     <= lsu_req_ready;
                        last_lsu      <= lsu_req_ready;
                        if (lsu_req_ready) begin
                            mem_addr      <= lsu_addr;
                            mem_wen       <= lsu_wen;
                            mem_wdata     <= lsu_wdata;
                            mem_wmask     <= lsu_wmask;
                            lsu_grant_cnt <= lsu_grant_cnt + 32'd1;
                        end else begin
                            mem_addr      <= ifu_addr;
                            mem_wen       <= 1'b0;
                            mem_wdata     <= '0;
                            mem_wmask     <= '0;
                            ifu_grant_cnt <= ifu_grant_cnt + 32'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                        to_cnt        <= to_cnt + 16'd1;
                    end else if (timed_out) begin
                        state          <= RESP;
                        mem_req_valid  <= 1'b0;
                        bus_err        <= 1'b1;
                        ifu_resp_valid <= !owner_lsu;
                        ifu_resp_err   <= !owner_lsu;
                        lsu_resp_valid <= owner_lsu;
                        lsu_resp_err   <= owner_lsu;
                        if (owner_lsu) lsu_rdata <= '0;
                        else           ifu_rdata <= '0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                WAIT: begin
                    // Stores report zero data; the response register is the owner's rdata.
                    if (mem_resp_valid) begin
                        state          <= RESP;
                        ifu_resp_valid <= !owner_lsu;
                        lsu_resp_valid <= owner_lsu;
                        if (owner_lsu) lsu_rdata <= mem_wen ? 32'd0 : mem_rdata;
                        else           ifu_rdata <= mem_rdata;
                    end else if (timed_out) begin
                        state          <= RESP;
                        bus_err        <= 1'b1;
                        ifu_resp_valid <= !owner_lsu;
                        ifu_resp_err   <= !owner_lsu;
                        lsu_resp_valid <= owner_lsu;
                        lsu_resp_err   <= owner_lsu;
                        if (owner_lsu) lsu_rdata <= '0;
                        else           ifu_rdata <= '0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    ifu_resp_valid <= 1'b0;
                    ifu_resp_err   <= 1'b0;
                    lsu_resp_valid <= 1'b0;
                    lsu_resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: round-robin instance (TIMEOUT=4) with a stimulus-controlled slave,
// plus a fixed-priority instance with an always-ready slave.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Round-robin instance
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask, mem_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ifu_grant_cnt, lsu_grant_cnt;
    logic        slave_rdy, slave_resp;
    logic [31:0] slave_rdata;

    assign mem_req_ready = slave_rdy;
    assign mem_rdata     = slave_rdata;
    always @(posedge clk or posedge rst) begin
        if (rst) mem_resp_valid <= 1'b0;
        else     mem_resp_valid <= mem_req_valid && mem_req_ready && slave_resp;
    end

    mem_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err),
        .ifu_grant_cnt(ifu_grant_cnt), .lsu_grant_cnt(lsu_grant_cnt)
    );

    // Fixed-priority instance
    logic        f_ifu_req_valid, f_ifu_req_ready, f_ifu_resp_valid, f_ifu_resp_err;
    logic [31:0] f_ifu_addr, f_ifu_rdata;
    logic        f_lsu_req_valid, f_lsu_req_ready, f_lsu_wen, f_lsu_resp_valid, f_lsu_resp_err;
    logic [31:0] f_lsu_addr, f_lsu_wdata, f_lsu_rdata;
    logic [3:0]  f_lsu_wmask, f_mem_wmask;
    logic        f_mem_req_valid, f_mem_req_ready, f_mem_wen, f_mem_resp_valid, f_bus_err;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata, f_ifu_grant_cnt, f_lsu_grant_cnt;

    assign f_mem_req_ready = 1'b1;
    assign f_mem_rdata     = 32'h0000_00AA;
    always @(posedge clk or posedge rst) begin
        if (rst) f_mem_resp_valid <= 1'b0;
        else     f_mem_resp_valid <= f_mem_req_valid && f_mem_req_ready;
    end

    mem_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT(4)) u_fp (
        .clk(clk), .rst(rst),
        .ifu_req_valid(f_ifu_req_valid), .ifu_req_ready(f_ifu_req_ready), .ifu_addr(f_ifu_addr),
        .ifu_resp_valid(f_ifu_resp_valid), .ifu_rdata(f_ifu_rdata), .ifu_resp_err(f_ifu_resp_err),
        .lsu_req_valid(f_lsu_req_valid), .lsu_req_ready(f_lsu_req_ready), .lsu_addr(f_lsu_addr),
        .lsu_wen(f_lsu_wen), .lsu_wdata(f_lsu_wdata), .lsu_wmask(f_lsu_wmask),
        .lsu_resp_valid(f_lsu_resp_valid), .lsu_rdata(f_lsu_rdata), .lsu_resp_err(f_lsu_resp_err),
        .mem_req_valid(f_mem_req_valid), .mem_req_ready(f_mem_req_ready), .mem_addr(f_mem_addr),
        .mem_wen(f_mem_wen), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
        .mem_resp_valid(f_mem_resp_valid), .mem_rdata(f_mem_rdata), .bus_err(f_bus_err),
        .ifu_grant_cnt(f_ifu_grant_cnt), .lsu_grant_cnt(f_lsu_grant_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 0 for an IFU accept, 1 for LSU, -1 if nothing was accepted in budget.
    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ifu_req_ready) begin who = 0; break; end
            if (lsu_req_ready) begin who = 1; break; end
            step();
        end
    endtask

    initial begin
        int who;
        int pulses;
        int f_grants;
        logic f_ifu_seen;

        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        slave_rdy = 0; slave_resp = 0; slave_rdata = 0;
        f_ifu_req_valid = 0; f_ifu_addr = 32'h8000_0000;
        f_lsu_req_valid = 0; f_lsu_addr = 32'h8000_0100; f_lsu_wen = 0;
        f_lsu_wdata = 0; f_lsu_wmask = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("reset_counters", ifu_grant_cnt | lsu_grant_cnt, 0);
        chk("reset_bus_err", bus_err, 0);
        rst = 1'b0;
        step();

        // IFU-only read
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        slave_rdy = 1; slave_resp = 1; slave_rdata = 32'h0000_0413;
        #1;
        chk("ifu_ready_T", ifu_req_ready, 1);
        chk("lsu_ready_T", lsu_req_ready, 0);
        step();
        ifu_req_valid = 0;
        chk("ifu_mem_req_valid_T1", mem_req_valid, 1);
        chk("ifu_mem_addr", mem_addr, 32'h8000_0000);
        chk("ifu_mem_wen", mem_wen, 0);
        chk("ifu_mem_wmask", mem_wmask, 0);
        chk("ifu_grant_cnt", ifu_grant_cnt, 1);
        step();
        chk("ifu_mem_req_valid_T2", mem_req_valid, 0);
        chk("ifu_resp_early", ifu_resp_valid, 0);
        step();
        chk("ifu_resp_valid_T3", ifu_resp_valid, 1);
        chk("ifu_rdata_T3", ifu_rdata, 32'h0000_0413);
        chk("ifu_resp_err_T3", ifu_resp_err, 0);
        chk("lsu_resp_during_ifu", lsu_resp_valid, 0);
        step();
        chk("ifu_resp_pulse_end", ifu_resp_valid, 0);

        // LSU store
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; slave_rdata = 32'h1234_5678;
        #1;
        chk("lsu_ready_store", lsu_req_ready, 1);
        step();
        lsu_req_valid = 0;
        chk("st_mem_req_valid", mem_req_valid, 1);
        chk("st_mem_wen", mem_wen, 1);
        chk("st_mem_addr", mem_addr, 32'h8000_1000);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_wmask", mem_wmask, 4'hF);
        step();
        step();
        chk("st_lsu_resp_valid", lsu_resp_valid, 1);
        chk("st_lsu_rdata_zero", lsu_rdata, 0);
        chk("st_ifu_resp_quiet", ifu_resp_valid, 0);
        chk("st_lsu_grant_cnt", lsu_grant_cnt, 1);
        step();

        // Timeout in ISSUE: slave never ready
        slave_rdy = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        #1;
        chk("to_ifu_ready", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0;
        repeat (4) step();
        chk("to_req_still_valid", mem_req_valid, 1);
        chk("to_no_resp_yet", ifu_resp_valid, 0);
        step();
        chk("to_req_dropped", mem_req_valid, 0);
        chk("to_resp_valid", ifu_resp_valid, 1);
        chk("to_resp_err", ifu_resp_err, 1);
        chk("to_rdata_zero", ifu_rdata, 0);
        chk("to_bus_err_set", bus_err, 1);
        step();
        chk("to_resp_pulse_end", ifu_resp_valid, 0);
        chk("to_bus_err_held", bus_err, 1);

        // Normal LSU load after the timeout
        slave_rdy = 1; slave_resp = 1; slave_rdata = 32'hCAFE_F00D;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
        step();
        lsu_req_valid = 0;
        step();
        step();
        chk("ld_resp_valid", lsu_resp_valid, 1);
        chk("ld_rdata", lsu_rdata, 32'hCAFE_F00D);
        chk("ld_resp_err", lsu_resp_err, 0);
        chk("ld_bus_err_sticky", bus_err, 1);
        step();

        // Reset during WAIT: slave accepts but never responds
        slave_resp = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
        step();
        ifu_req_valid = 0;
        step();
        chk("wait_entered", mem_req_valid, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_counters", ifu_grant_cnt | lsu_grant_cnt, 0);
        chk("arst_bus_err", bus_err, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        step();
        rst = 1'b0;
        slave_resp = 1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (ifu_resp_valid || lsu_resp_valid) pulses++;
            step();
        end
        chk("arst_no_resp_pulse", 32'(pulses), 0);

        // Round-robin with both masters continuously valid
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(who);
            chk("rr_grant_order", 32'(who), (g % 2 == 0) ? 32'd0 : 32'd1);
            step();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (lsu_resp_valid) break;
            step();
        end
        chk("rr_last_resp_lsu", lsu_resp_valid, 1);
        chk("rr_ifu_cnt", ifu_grant_cnt, 2);
        chk("rr_lsu_cnt", lsu_grant_cnt, 2);

        // Fixed priority: LSU always wins a tie
        f_ifu_req_valid = 1; f_lsu_req_valid = 1;
        f_grants = 0; f_ifu_seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (f_ifu_req_ready) f_ifu_seen = 1;
            if (f_lsu_req_ready) f_grants++;
            step();
            if (f_grants == 3) break;
        end
        f_ifu_req_valid = 0; f_lsu_req_valid = 0;
        chk("fp_ifu_never_ready", f_ifu_seen, 0);
        chk("fp_lsu_grants", f_lsu_grant_cnt, 3);
        chk("fp_ifu_grants", f_ifu_grant_cnt, 0);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
